// File: rtl/key_event_reader_pkg.sv
// Shared definitions for the key event reader: event word layout, default key count
// and a ceiling-log2 helper used to size counters and pointers.
package key_event_reader_pkg;

  localparam int EV_PRESS_BIT = 0;
  localparam int EV_KEY_LSB   = 1;
  localparam int DEF_NKEYS    = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead event queue: the head entry sits in an output register, so dout is valid
// whenever empty is low and holds its last value once the queue drains.
module key_event_fifo
  import key_event_reader_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_ok, wr_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  // A read frees its slot before the write is considered, so full+read+write is accepted.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    dout_d   = dout_q;
    // The new head may be the word being written this very cycle.
    if (count_d != '0) begin
      if (wr_ok && (wr_ptr_q == rd_ptr_d)) dout_d = din;
      else                                 dout_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/key_event_reader.sv
// Synchronises and debounces latched key levels, converts each accepted level change
// into a press/release event and queues it for the consumer over valid/ready.
module key_event_reader
  import key_event_reader_pkg::*;
#(
  parameter int NKEYS      = DEF_NKEYS,
  parameter int DEB_CYCLES = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int KW = (NKEYS > 1) ? clog2(NKEYS) : 1,
  localparam int CW = clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_q,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [KW-1:0]    ev_key,
  output logic             ev_press,
  output logic [CW-1:0]    ev_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int DW = clog2(DEB_CYCLES);
  localparam int EW = KW + 1;

  logic [NKEYS-1:0] s1_q, s2_q;
  logic [NKEYS-1:0] pend_vec, dir_vec, lost_vec, grant;
  logic [KW-1:0]    sel_idx;
  logic             sel_dir, wr_req, drop;
  logic [EW-1:0]    ev_din, ev_dout;
  logic             fifo_full, fifo_empty;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_q;
      s2_q <= s1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic [DW-1:0] cnt_q, cnt_d;
      logic          stable_q, stable_d, pend_q, pend_d, dir_q, dir_d, flip;

      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pend_d   = pend_q & ~grant[gi];
        dir_d    = dir_q;
        flip     = 1'b0;
        if (s2_q[gi] == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          flip     = 1'b1;
          cnt_d    = '0;
          stable_d = s2_q[gi];
          pend_d   = 1'b1;
          dir_d    = s2_q[gi];
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          pend_q   <= 1'b0;
          dir_q    <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
          pend_q   <= pend_d;
          dir_q    <= dir_d;
        end
      end

      assign pend_vec[gi] = pend_q;
      assign dir_vec[gi]  = dir_q;
      // A flip landing on an unserved pending event overwrites it.
      assign lost_vec[gi] = flip & pend_q & ~grant[gi];
    end
  endgenerate

  // Lowest-index pending key wins.
  assign grant  = pend_vec & (~pend_vec + NKEYS'(1));
  assign wr_req = |pend_vec;

  always_comb begin
    sel_idx = '0;
    sel_dir = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (grant[i]) begin
        sel_idx = KW'(i);
        sel_dir = dir_vec[i];
      end
    end
  end

  always_comb begin
    ev_din                     = '0;
    ev_din[EV_PRESS_BIT]       = sel_dir;
    ev_din[EV_KEY_LSB +: KW]   = sel_idx;
  end

  key_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_req),
    .din   (ev_din),
    .full  (fifo_full),
    .rd_en (ev_ready),
    .dout  (ev_dout),
    .empty (fifo_empty),
    .count (ev_count)
  );

  assign drop       = wr_req & fifo_full & ~ev_ready;
  assign overflow_d = (overflow_q & ~clr_ovf) | drop | (|lost_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
  assign ev_valid = ~fifo_empty;
  assign ev_key   = ev_dout[EV_KEY_LSB +: KW];
  assign ev_press = ev_dout[EV_PRESS_BIT];

endmodule
